cobra_core_p: RTL and testbench
===============================

COBRA_CORE_P -- requirements
Module: cobra_core_p

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and register width (>=8).
REQ-002 SHALL have parameter PC_W, default 8, instruction address width in bytes.
REQ-003 SHALL have parameter OUT_REG, default 1, index (1..31) of the register mirrored to out_data.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port instr_addr  output  PC_W  byte address of the current instruction, equal to the PC.
REQ-007 SHALL have port instr  input  32  instruction word, combinationally valid for instr_addr in the same cycle.
REQ-008 SHALL have port in_data  input  WIDTH  external input operand.
REQ-009 SHALL have port in_valid  input  1  in_data is valid.
REQ-010 SHALL have port in_ready  output  1  core consumes in_data this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  current value of x[OUT_REG].
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse: x[OUT_REG] was written on the previous edge.
REQ-013 SHALL have port pc_dbg  output  PC_W  copy of the PC.
REQ-014 SHALL have port halted  output  1  core is in the HALT state.

Function
REQ-015 Instruction fields SHALL be: J=[31], B=[30], WS=[29:28], ALUop=[27:23], RA1=[22:18], RA2=[17:13], offset=[12:5] (8-bit signed), WA=[4:0], const=[27:5] (23-bit, sign-extended to WIDTH).
REQ-016 The register file SHALL hold 32 x WIDTH registers with two combinational reads (RA1, RA2) and one synchronous write; x0 reads 0 always and writes to it are discarded.
REQ-017 WS SHALL select the write data: 00 = sign-extended const, 01 = ALU result, 10 = in_data, 11 = HALT opcode.
REQ-018 A register write SHALL occur only when J=0, B=0, state=RUN and the instruction is not stalled (REQ-021).
REQ-019 ALUop encodings SHALL be: ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111; shift amounts use the low log2(WIDTH) bits of operand B; SLT/SLTU yield 1 or 0 zero-extended.
REQ-020 Flag encodings SHALL be: EQ 11000, NE 11001, LT 11100, GE 11101, LTU 11110, GEU 11111; any unlisted ALUop yields result 0, flag 0.
REQ-021 With WS=10, J=0 and B=0 in RUN, the core SHALL stall (PC held, no write) while in_valid=0; in_ready SHALL equal in_valid for that instruction and be 0 otherwise; the write and PC advance occur on the edge where in_valid=1.
REQ-022 Next PC SHALL be PC + (sign-extended offset << 2) when J=1, or when B=1 and flag=1; otherwise PC + 4; arithmetic is modulo 2^PC_W (wrap-around, no error).
REQ-023 J=1 SHALL take priority over B and WS; J=1 or B=1 never writes or stalls, regardless of WS.
REQ-024 State machine SHALL have states RUN and HALT; RUN -> HALT on an instruction with WS=11, J=0, B=0; HALT is left only by reset.
REQ-025 In HALT the PC SHALL hold, no register write occurs, in_ready=0, out_valid=0, halted=1.
REQ-026 out_valid SHALL be registered: 1 in the cycle following an edge that wrote register OUT_REG, including writes of an unchanged value.
REQ-027 Offset 0 with J=1 SHALL hold the PC (legal self-loop).

Reset
REQ-028 While rst=1 at a rising edge: PC=0, all registers=0, state=RUN, out_valid=0; in_ready=0 and halted=0 during and after reset.
REQ-029 Reset SHALL take priority over every other event, including a pending stall, a write in the same cycle, and HALT.
REQ-030 The first instruction executed after reset is the one at address 0, on the first edge with rst=0.

Verification
REQ-031 Const/ALU: x1=const 5, x2=const -3, x1=ADD x1,x2 -> out_data 5 then 2, out_valid pulses twice, pc_dbg 0,4,8,12.
REQ-032 Branch: x3=const 7, BLT x0,x3 offset -2 at addr 4 -> PC returns to 0 repeatedly; with GE same operands -> PC advances to 8, no register changes.
REQ-033 Input stall: WS=10 WA=1 at addr 0, in_valid low 3 cycles then high with in_data=0xA5 -> PC held at 0 for 3 cycles, in_ready high 1 cycle, x1=0xA5, out_valid pulse, PC=4.
REQ-034 Halt: WS=11 at addr 8 -> halted=1 from next cycle, PC stays 8 for 10 cycles, in_valid=1 ignored (in_ready=0).
REQ-035 Wrap: PC_W=8, J=1 offset +1 at addr 252 -> next PC 0; write to x0 -> x0 still reads 0.
REQ-036 Reset mid-stall and in HALT: assert rst for 1 cycle -> PC=0, x1..x31=0, halted=0, out_valid=0, execution restarts at address 0.

Source files
------------

// File: rtl/cobra_core_p.sv
// cobra_core_p: single-cycle accumulator-free RISC core with a 32-entry
// register file, ALU, compare-and-branch, blocking input port and a HALT state.
module cobra_core_p #(
  parameter int WIDTH   = 32,
  parameter int PC_W    = 8,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  instr_addr,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [PC_W-1:0]  pc_dbg,
  output logic             halted
);

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_EQ   = 5'b11000;
  localparam logic [4:0] OP_NE   = 5'b11001;
  localparam logic [4:0] OP_LT   = 5'b11100;
  localparam logic [4:0] OP_GE   = 5'b11101;
  localparam logic [4:0] OP_LTU  = 5'b11110;
  localparam logic [4:0] OP_GEU  = 5'b11111;

  localparam logic [1:0] WS_CONST = 2'b00;
  localparam logic [1:0] WS_ALU   = 2'b01;
  localparam logic [1:0] WS_IN    = 2'b10;
  localparam logic [1:0] WS_HALT  = 2'b11;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t             state, state_next;
  logic [PC_W-1:0]    pc, pc_next;
  logic [WIDTH-1:0]   regs [32];

  // Decoded instruction fields
  logic               f_j, f_b;
  logic [1:0]         f_ws;
  logic [4:0]         f_op, f_ra1, f_ra2, f_wa;
  logic [7:0]         f_off;
  logic [WIDTH-1:0]   const_ext;
  logic [PC_W-1:0]    br_off;

  logic [WIDTH-1:0]   op_a, op_b, alu_res, wr_data;
  logic [SH_W-1:0]    sh;
  logic               flag;
  logic               run_en, plain, in_instr, stall, halt_instr, wr_en;

  assign f_j   = instr[31];
  assign f_b   = instr[30];
  assign f_ws  = instr[29:28];
  assign f_op  = instr[27:23];
  assign f_ra1 = instr[22:18];
  assign f_ra2 = instr[17:13];
  assign f_off = instr[12:5];
  assign f_wa  = instr[4:0];

  assign const_ext = WIDTH'($signed(instr[27:5]));
  assign br_off    = PC_W'($signed({f_off, 2'b00}));

  assign op_a = (f_ra1 == 5'd0) ? '0 : regs[f_ra1];
  assign op_b = (f_ra2 == 5'd0) ? '0 : regs[f_ra2];
  assign sh   = op_b[SH_W-1:0];

  assign instr_addr = pc;
  assign pc_dbg     = pc;
  assign out_data   = regs[OUT_REG];

  // ALU result and branch flag from the two register operands
  always_comb begin
    alu_res = '0;
    flag    = 1'b0;
    case (f_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << sh;
      OP_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res = WIDTH'(op_a < op_b);
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> sh;
      OP_SRA:  alu_res = $signed(op_a) >>> sh;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_EQ:   flag = (op_a == op_b);
      OP_NE:   flag = (op_a != op_b);
      OP_LT:   flag = ($signed(op_a) < $signed(op_b));
      OP_GE:   flag = ($signed(op_a) >= $signed(op_b));
      OP_LTU:  flag = (op_a < op_b);
      OP_GEU:  flag = (op_a >= op_b);
      default: begin
        alu_res = '0;
        flag    = 1'b0;
      end
    endcase
  end

  // Write-back source selection
  always_comb begin
    wr_data = '0;
    case (f_ws)
      WS_CONST: wr_data = const_ext;
      WS_ALU:   wr_data = alu_res;
      WS_IN:    wr_data = in_data;
      default:  wr_data = '0;
    endcase
  end

  // Instruction classification; jumps and branches never write or stall
  assign plain      = !f_j && !f_b;
  assign in_instr   = run_en && plain && (f_ws == WS_IN);
  assign stall      = in_instr && !in_valid;
  assign halt_instr = run_en && plain && (f_ws == WS_HALT);
  assign wr_en      = run_en && plain && (f_ws != WS_HALT) && !stall;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // FSM next state: HALT is absorbing until reset
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:  if (halt_instr) state_next = ST_HALT;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RUN;
    endcase
  end

  // FSM outputs, forced inactive while reset is asserted
  always_comb begin
    run_en   = 1'b0;
    halted   = 1'b0;
    in_ready = 1'b0;
    case (state)
      ST_RUN: begin
        run_en   = !rst;
        in_ready = !rst && plain && (f_ws == WS_IN) && in_valid;
      end
      ST_HALT: halted = !rst;
      default: run_en = 1'b0;
    endcase
  end

  // Next PC: jump, taken branch, hold on stall/halt, otherwise sequential
  always_comb begin
    pc_next = pc;
    if (run_en) begin
      if (f_j)                       pc_next = pc + br_off;
      else if (f_b)                  pc_next = flag ? (pc + br_off) : (pc + PC_W'(4));
      else if (halt_instr || stall)  pc_next = pc;
      else                           pc_next = pc + PC_W'(4);
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) pc <= '0;
    else     pc <= pc_next;
  end

  // Register file write port; x0 stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (f_wa != 5'd0)) begin
      regs[f_wa] <= wr_data;
    end
  end

  // Pulse out_valid the cycle after any write to the mirrored register
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= wr_en && (f_wa == 5'(OUT_REG));
  end

endmodule

// File: tb/tb_cobra_core_p.sv
// Directed testbench for cobra_core_p: small programs in a bench-side
// instruction memory with hand-computed expected outputs.
module tb_cobra_core_p;

  logic        clk;
  logic        rst;
  logic [7:0]  instr_addr;
  logic [31:0] instr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic [7:0]  pc_dbg;
  logic        halted;

  logic [31:0] mem [64];
  int tests_run;
  int tests_failed;

  cobra_core_p #(.WIDTH(32), .PC_W(8), .OUT_REG(1)) dut (
    .clk(clk),
    .rst(rst),
    .instr_addr(instr_addr),
    .instr(instr),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .pc_dbg(pc_dbg),
    .halted(halted)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction fetch
  assign instr = mem[instr_addr[7:2]];

  function automatic logic [31:0] enc(input logic j, input logic b, input logic [1:0] ws,
                                      input logic [4:0] op, input logic [4:0] ra1,
                                      input logic [4:0] ra2, input logic [7:0] off,
                                      input logic [4:0] wa);
    return {j, b, ws, op, ra1, ra2, off, wa};
  endfunction

  function automatic logic [31:0] mk_const(input logic [4:0] wa, input logic [22:0] v);
    return {4'b0000, v, wa};
  endfunction

  function automatic logic [31:0] mk_alu(input logic [4:0] op, input logic [4:0] ra1,
                                         input logic [4:0] ra2, input logic [4:0] wa);
    return enc(1'b0, 1'b0, 2'b01, op, ra1, ra2, 8'h00, wa);
  endfunction

  function automatic logic [31:0] mk_jmp(input logic [7:0] off);
    return enc(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, off, 5'd0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = 32'h0;
    clear_mem();

    // Const / ADD program with a self-loop at 12
    mem[0] = mk_const(5'd1, 23'd5);
    mem[1] = mk_const(5'd2, 23'h7FFFFD);
    mem[2] = mk_alu(5'b00000, 5'd1, 5'd2, 5'd1);
    mem[3] = mk_jmp(8'h00);
    do_reset();
    check("rst_pc", {24'h0, pc_dbg}, 32'd0);
    check("rst_out", out_data, 32'd0);
    check("rst_ov", {31'h0, out_valid}, 32'd0);
    check("rst_halted", {31'h0, halted}, 32'd0);
    check("rst_ready", {31'h0, in_ready}, 32'd0);
    step();
    check("c_pc4", {24'h0, pc_dbg}, 32'd4);
    check("c_x1_5", out_data, 32'd5);
    check("c_ov1", {31'h0, out_valid}, 32'd1);
    step();
    check("c_pc8", {24'h0, pc_dbg}, 32'd8);
    check("c_ov_x2", {31'h0, out_valid}, 32'd0);
    step();
    check("c_pc12", {24'h0, pc_dbg}, 32'd12);
    check("c_x1_2", out_data, 32'd2);
    check("c_ov2", {31'h0, out_valid}, 32'd1);
    step();
    check("c_selfloop", {24'h0, pc_dbg}, 32'd12);
    check("c_ov_idle", {31'h0, out_valid}, 32'd0);

    // ALU operations: x2 = -8, x3 = 2
    clear_mem();
    mem[0]  = mk_const(5'd2, 23'h7FFFF8);
    mem[1]  = mk_const(5'd3, 23'd2);
    mem[2]  = mk_alu(5'b01101, 5'd2, 5'd3, 5'd1);
    mem[3]  = mk_alu(5'b00101, 5'd2, 5'd3, 5'd1);
    mem[4]  = mk_alu(5'b00010, 5'd2, 5'd3, 5'd1);
    mem[5]  = mk_alu(5'b00011, 5'd2, 5'd3, 5'd1);
    mem[6]  = mk_alu(5'b01000, 5'd3, 5'd2, 5'd1);
    mem[7]  = mk_alu(5'b00100, 5'd2, 5'd3, 5'd1);
    mem[8]  = mk_alu(5'b01001, 5'd2, 5'd3, 5'd1);
    mem[9]  = mk_alu(5'b00001, 5'd3, 5'd3, 5'd1);
    mem[10] = mk_alu(5'b00110, 5'd3, 5'd0, 5'd1);
    mem[11] = mk_alu(5'b00111, 5'd2, 5'd3, 5'd1);
    mem[12] = mk_jmp(8'h00);
    do_reset();
    step();
    step();
    step();
    check("alu_sra", out_data, 32'hFFFF_FFFE);
    step();
    check("alu_srl", out_data, 32'h3FFF_FFFE);
    step();
    check("alu_slt", out_data, 32'd1);
    step();
    check("alu_sltu", out_data, 32'd0);
    step();
    check("alu_sub", out_data, 32'd10);
    step();
    check("alu_xor", out_data, 32'hFFFF_FFFA);
    step();
    check("alu_unlisted", out_data, 32'd0);
    step();
    check("alu_sll", out_data, 32'd8);
    step();
    check("alu_or", out_data, 32'd2);
    step();
    check("alu_and", out_data, 32'd0);
    check("alu_pc", {24'h0, pc_dbg}, 32'd48);

    // Registers cleared by reset: x1 = x2 + x3 must be 0, and the write still pulses
    clear_mem();
    mem[0] = mk_alu(5'b00000, 5'd2, 5'd3, 5'd1);
    mem[1] = mk_jmp(8'h00);
    mem[2] = mk_const(5'd1, 23'd77);
    step();
    do_reset();
    step();
    check("clr_x1", out_data, 32'd0);
    check("clr_ov_same", {31'h0, out_valid}, 32'd1);

    // BLT x0,x3 taken backwards: 0 -> 4 -> 252 -> 0 ...
    clear_mem();
    mem[0] = mk_const(5'd3, 23'd7);
    mem[1] = enc(1'b0, 1'b1, 2'b00, 5'b11100, 5'd0, 5'd3, 8'hFE, 5'd1);
    do_reset();
    step();
    check("blt_pc4", {24'h0, pc_dbg}, 32'd4);
    step();
    check("blt_pc252", {24'h0, pc_dbg}, 32'd252);
    check("blt_nowr", {31'h0, out_valid}, 32'd0);
    step();
    check("blt_pc0", {24'h0, pc_dbg}, 32'd0);
    step();
    step();
    check("blt_again", {24'h0, pc_dbg}, 32'd252);
    check("blt_x1", out_data, 32'd0);

    // BGE with the same operands is not taken
    mem[1] = enc(1'b0, 1'b1, 2'b00, 5'b11101, 5'd0, 5'd3, 8'hFE, 5'd1);
    mem[2] = mk_jmp(8'h00);
    do_reset();
    step();
    step();
    check("bge_pc8", {24'h0, pc_dbg}, 32'd8);
    check("bge_x1", out_data, 32'd0);
    check("bge_ov", {31'h0, out_valid}, 32'd0);

    // Wrap-around and x0 write discard
    clear_mem();
    mem[0]  = mk_const(5'd0, 23'd5);
    mem[1]  = mk_alu(5'b00000, 5'd0, 5'd0, 5'd1);
    mem[2]  = mk_jmp(8'd61);
    mem[63] = mk_jmp(8'd1);
    do_reset();
    step();
    step();
    check("x0_zero", out_data, 32'd0);
    check("x0_ov", {31'h0, out_valid}, 32'd1);
    step();
    check("wrap_pc252", {24'h0, pc_dbg}, 32'd252);
    step();
    check("wrap_pc0", {24'h0, pc_dbg}, 32'd0);

    // Input stall then accept
    clear_mem();
    mem[0] = enc(1'b0, 1'b0, 2'b10, 5'd0, 5'd0, 5'd0, 8'h00, 5'd1);
    mem[1] = mk_jmp(8'h00);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", {24'h0, pc_dbg}, 32'd0);
      check("stall_ready", {31'h0, in_ready}, 32'd0);
      check("stall_ov", {31'h0, out_valid}, 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 32'h0000_00A5;
    #1;
    check("in_ready_hi", {31'h0, in_ready}, 32'd1);
    step();
    check("in_pc4", {24'h0, pc_dbg}, 32'd4);
    check("in_x1", out_data, 32'h0000_00A5);
    check("in_ov", {31'h0, out_valid}, 32'd1);
    check("in_ready_jmp", {31'h0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Reset in the middle of a stall, with in_valid rising on the reset edge
    do_reset();
    step();
    step();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0033;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mrst_pc", {24'h0, pc_dbg}, 32'd0);
    check("mrst_x1", out_data, 32'd0);
    check("mrst_ov", {31'h0, out_valid}, 32'd0);
    step();
    check("mrst_stall", {24'h0, pc_dbg}, 32'd0);

    // HALT at address 8
    clear_mem();
    mem[0] = mk_const(5'd1, 23'd1);
    mem[1] = mk_const(5'd2, 23'd2);
    mem[2] = enc(1'b0, 1'b0, 2'b11, 5'd0, 5'd0, 5'd0, 8'h00, 5'd1);
    mem[3] = mk_const(5'd1, 23'd9);
    do_reset();
    step();
    step();
    check("h_pc8", {24'h0, pc_dbg}, 32'd8);
    check("h_not_yet", {31'h0, halted}, 32'd0);
    step();
    in_valid = 1'b1;
    in_data  = 32'h0000_0055;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("h_halted", {31'h0, halted}, 32'd1);
      check("h_pc", {24'h0, pc_dbg}, 32'd8);
      check("h_ready", {31'h0, in_ready}, 32'd0);
      check("h_ov", {31'h0, out_valid}, 32'd0);
      step();
    end
    check("h_x1", out_data, 32'd1);

    // Reset out of HALT restarts at address 0
    rst = 1'b1;
    #1;
    check("hr_halted_during", {31'h0, halted}, 32'd0);
    check("hr_ready_during", {31'h0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("hr_pc", {24'h0, pc_dbg}, 32'd0);
    check("hr_halted", {31'h0, halted}, 32'd0);
    check("hr_ov", {31'h0, out_valid}, 32'd0);
    check("hr_x1", out_data, 32'd0);
    step();
    check("hr_restart_pc", {24'h0, pc_dbg}, 32'd4);
    check("hr_restart_x1", out_data, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
